// File: rtl/fir_ctrl_if.sv
// ---------------------------------------------------------------------------
// fir_ctrl_if
//   Bundles the streaming handshakes and the RAM / MAC control strobes that
//   the FIR sequencer drives toward the datapath.
//
//   master : the sequencer (drives readies/valids, RAM controls, MAC strobes)
//   slave  : the surrounding datapath / stream endpoints
//
//   ss_tvalid, ss_tlast, ss_tready : input AXI-Stream handshake
//   sm_tvalid, sm_tlast, sm_tready : output AXI-Stream handshake
//   data_EN, data_WE, data_A, data_zero : circular data RAM port control
//   tap_EN, tap_A                  : tap RAM read control
//   mac_clr, mac_en                : accumulator clear / accumulate strobes
// ---------------------------------------------------------------------------
interface fir_ctrl_if #(
    parameter int pADDR_WIDTH = 12
);
    logic                   ss_tvalid;
    logic                   ss_tlast;
    logic                   ss_tready;

    logic                   sm_tvalid;
    logic                   sm_tlast;
    logic                   sm_tready;

    logic                   data_EN;
    logic [3:0]             data_WE;
    logic [pADDR_WIDTH-1:0] data_A;
    logic                   data_zero;

    logic                   tap_EN;
    logic [pADDR_WIDTH-1:0] tap_A;

    logic                   mac_clr;
    logic                   mac_en;

    modport master (
        input  ss_tvalid, ss_tlast, sm_tready,
        output ss_tready, sm_tvalid, sm_tlast,
        output data_EN, data_WE, data_A, data_zero,
        output tap_EN, tap_A,
        output mac_clr, mac_en
    );

    modport slave (
        output ss_tvalid, ss_tlast, sm_tready,
        input  ss_tready, sm_tvalid, sm_tlast,
        input  data_EN, data_WE, data_A, data_zero,
        input  tap_EN, tap_A,
        input  mac_clr, mac_en
    );
endinterface

// File: rtl/fir_ctrl.sv
// ---------------------------------------------------------------------------
// fir_ctrl
//   Sequencing controller for the 11-tap FIR engine. Runs the ap_ctrl
//   start/done/idle protocol, zero-fills the circular data RAM at start,
//   accepts one input sample at a time, walks the 11 taps against the most
//   recent 11 samples, then presents one output beat.
//
//   axis_clk, axis_rst : clock (rising edge) and synchronous active-high reset
//   start              : one-cycle pulse, software wrote ap_start
//   ap_ctrl_rd         : one-cycle pulse, ap_ctrl register was read
//   data_length        : number of samples, captured on an accepted start
//   ap_start/ap_done/ap_idle : ap_ctrl status bits
//   tap_grant          : AXI-Lite side may own the tap RAM (engine idle)
//   err_tlast          : sticky, ss_tlast disagreed with the sample count
//   bus                : stream handshakes, RAM controls and MAC strobes
// ---------------------------------------------------------------------------
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   start,
    input  logic                   ap_ctrl_rd,
    input  logic [pDATA_WIDTH-1:0] data_length,
    output logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic                   tap_grant,
    output logic                   err_tlast,
    fir_ctrl_if.master             bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_WAIT_IN = 3'd2;
    localparam logic [2:0] S_MAC     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    // Highest index of both the tap RAM and the circular data RAM.
    localparam logic [3:0] LAST_IDX  = 4'(Tape_Num - 1);
    localparam logic [3:0] DEPTH     = 4'(Tape_Num);

    logic [2:0]             state_reg,     state_next;
    logic [pDATA_WIDTH-1:0] len_reg,       len_next;
    logic [pDATA_WIDTH-1:0] n_reg,         n_next;
    logic [3:0]             wptr_reg,      wptr_next;
    // k doubles as the clear index i in CLEAR and the tap index in MAC.
    logic [3:0]             k_reg,         k_next;
    logic                   ap_start_reg,  ap_start_next;
    logic                   ap_done_reg,   ap_done_next;
    logic                   err_tlast_reg, err_tlast_next;
    logic                   mac_en_reg;

    logic                   is_last;
    logic [3:0]             rd_idx;

    // Byte address of a 32-bit word in an 11-entry RAM.
    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [3:0] idx);
        return pADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign is_last = (n_reg == len_reg - pDATA_WIDTH'(1));

    // Sample k positions older than the newest one, modulo the RAM depth.
    // Done with a compare instead of % so it stays a small adder.
    assign rd_idx = (wptr_reg >= k_reg) ? (wptr_reg - k_reg)
                                        : (wptr_reg + DEPTH - k_reg);

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        n_next         = n_reg;
        wptr_next      = wptr_reg;
        k_next         = k_reg;
        ap_start_next  = ap_start_reg;
        ap_done_next   = ap_done_reg;
        err_tlast_next = err_tlast_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    len_next      = data_length;
                    n_next        = '0;
                    wptr_next     = '0;
                    k_next        = '0;
                    ap_start_next = 1'b1;
                    ap_done_next  = 1'b0;
                    state_next    = S_CLEAR;
                end else if (ap_ctrl_rd) begin
                    ap_done_next  = 1'b0;
                end
            end

            S_CLEAR: begin
                if (k_reg == LAST_IDX) begin
                    k_next = '0;
                    if (len_reg == '0) begin
                        // Nothing to stream: finish straight away.
                        ap_start_next = 1'b0;
                        ap_done_next  = 1'b1;
                        state_next    = S_IDLE;
                    end else begin
                        state_next    = S_WAIT_IN;
                    end
                end else begin
                    k_next = k_reg + 4'd1;
                end
            end

            S_WAIT_IN: begin
                if (bus.ss_tvalid) begin
                    ap_start_next = 1'b0;
                    if (bus.ss_tlast != is_last) begin
                        err_tlast_next = 1'b1;
                    end
                    k_next     = '0;
                    state_next = S_MAC;
                end
            end

            S_MAC: begin
                if (k_reg == LAST_IDX) begin
                    k_next     = '0;
                    state_next = S_DRAIN;
                end else begin
                    k_next     = k_reg + 4'd1;
                end
            end

            // Lets the product of the last tap reach the accumulator.
            S_DRAIN: begin
                state_next = S_OUT;
            end

            S_OUT: begin
                if (bus.sm_tready) begin
                    wptr_next = (wptr_reg == LAST_IDX) ? 4'd0 : wptr_reg + 4'd1;
                    n_next    = n_reg + pDATA_WIDTH'(1);
                    if (is_last) begin
                        ap_done_next = 1'b1;
                        state_next   = S_IDLE;
                    end else begin
                        state_next   = S_WAIT_IN;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            n_reg         <= '0;
            wptr_reg      <= '0;
            k_reg         <= '0;
            ap_start_reg  <= 1'b0;
            ap_done_reg   <= 1'b0;
            err_tlast_reg <= 1'b0;
            mac_en_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            n_reg         <= n_next;
            wptr_reg      <= wptr_next;
            k_reg         <= k_next;
            ap_start_reg  <= ap_start_next;
            ap_done_reg   <= ap_done_next;
            err_tlast_reg <= err_tlast_next;
            // One cycle behind MAC to line up with the RAM read latency.
            mac_en_reg    <= (state_reg == S_MAC);
        end
    end

    // ------------------------------------------------------------------
    // Output decode (no registers except mac_en)
    // ------------------------------------------------------------------
    always_comb begin
        bus.ss_tready = 1'b0;
        bus.sm_tvalid = 1'b0;
        bus.sm_tlast  = 1'b0;
        bus.data_EN   = 1'b0;
        bus.data_WE   = 4'h0;
        bus.data_A    = '0;
        bus.data_zero = 1'b0;
        bus.tap_EN    = 1'b0;
        bus.tap_A     = '0;
        bus.mac_clr   = 1'b0;

        case (state_reg)
            S_CLEAR: begin
                bus.data_EN   = 1'b1;
                bus.data_WE   = 4'hF;
                bus.data_zero = 1'b1;
                bus.data_A    = word_addr(k_reg);
            end

            S_WAIT_IN: begin
                bus.ss_tready = 1'b1;
                if (bus.ss_tvalid) begin
                    bus.data_EN = 1'b1;
                    bus.data_WE = 4'hF;
                    bus.data_A  = word_addr(wptr_reg);
                    bus.mac_clr = 1'b1;
                end
            end

            S_MAC: begin
                bus.tap_EN  = 1'b1;
                bus.tap_A   = word_addr(k_reg);
                bus.data_EN = 1'b1;
                bus.data_A  = word_addr(rd_idx);
            end

            S_OUT: begin
                bus.sm_tvalid = 1'b1;
                bus.sm_tlast  = is_last;
            end

            default: begin
            end
        endcase
    end

    assign bus.mac_en = mac_en_reg;
    assign ap_start   = ap_start_reg;
    assign ap_done    = ap_done_reg;
    assign ap_idle    = (state_reg == S_IDLE);
    // Tap RAM belongs to the register side only while the engine is idle.
    assign tap_grant  = (state_reg == S_IDLE);
    assign err_tlast  = err_tlast_reg;

endmodule

// File: tb/tb_fir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_ctrl
//   Drives fir_ctrl through start/clear, single and multi-sample streams,
//   output backpressure, RAM wrap-around, tlast errors, ignored starts,
//   zero-length runs and a reset in the middle of the tap walk. Expected
//   addresses and flags come from sample-level arithmetic (sample index
//   modulo the RAM depth, sample count against the length).
// ---------------------------------------------------------------------------
module tb_fir_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int NTAPS = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ap_ctrl_rd;
    logic [DW-1:0] data_length;
    logic          ap_start, ap_done, ap_idle, tap_grant, err_tlast;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit err_model = 1'b0;

    fir_ctrl_if #(.pADDR_WIDTH(AW)) bus ();

    fir_ctrl #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .Tape_Num    (NTAPS)
    ) dut (
        .axis_clk    (clk),
        .axis_rst    (rst),
        .start       (start),
        .ap_ctrl_rd  (ap_ctrl_rd),
        .data_length (data_length),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .tap_grant   (tap_grant),
        .err_tlast   (err_tlast),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and drop every pulse/handshake input.
    task automatic step();
        @(negedge clk);
        start          = 1'b0;
        ap_ctrl_rd     = 1'b0;
        bus.ss_tvalid  = 1'b0;
        bus.ss_tlast   = 1'b0;
        bus.sm_tready  = 1'b0;
    endtask

    task automatic check_reset_state(input string where);
        check({where, ".ap_idle"},   32'(ap_idle),       32'd1);
        check({where, ".tap_grant"}, 32'(tap_grant),     32'd1);
        check({where, ".ap_start"},  32'(ap_start),      32'd0);
        check({where, ".ap_done"},   32'(ap_done),       32'd0);
        check({where, ".err_tlast"}, 32'(err_tlast),     32'd0);
        check({where, ".ss_tready"}, 32'(bus.ss_tready), 32'd0);
        check({where, ".sm_tvalid"}, 32'(bus.sm_tvalid), 32'd0);
        check({where, ".sm_tlast"},  32'(bus.sm_tlast),  32'd0);
        check({where, ".data_EN"},   32'(bus.data_EN),   32'd0);
        check({where, ".data_WE"},   32'(bus.data_WE),   32'd0);
        check({where, ".data_A"},    32'(bus.data_A),    32'd0);
        check({where, ".data_zero"}, 32'(bus.data_zero), 32'd0);
        check({where, ".tap_EN"},    32'(bus.tap_EN),    32'd0);
        check({where, ".tap_A"},     32'(bus.tap_A),     32'd0);
        check({where, ".mac_clr"},   32'(bus.mac_clr),   32'd0);
        check({where, ".mac_en"},    32'(bus.mac_en),    32'd0);
    endtask

    // Start pulse followed by the 11-cycle zero fill of the data RAM.
    task automatic do_clear(input int len);
        step();
        start       = 1'b1;
        data_length = 32'(len);
        #1;
        check("start.ap_idle_before", 32'(ap_idle), 32'd1);
        for (int i = 0; i < NTAPS; i++) begin
            step();
            #1;
            check("clr.ap_idle",   32'(ap_idle),       32'd0);
            check("clr.tap_grant", 32'(tap_grant),     32'd0);
            check("clr.ap_start",  32'(ap_start),      32'd1);
            check("clr.ap_done",   32'(ap_done),       32'd0);
            check("clr.data_EN",   32'(bus.data_EN),   32'd1);
            check("clr.data_WE",   32'(bus.data_WE),   32'hF);
            check("clr.data_zero", 32'(bus.data_zero), 32'd1);
            check("clr.data_A",    32'(bus.data_A),    32'(4 * i));
            check("clr.ss_tready", 32'(bus.ss_tready), 32'd0);
        end
        $display("txn: start len=%0d, clear done", len);
    endtask

    // One input sample s (0-based) through accept, tap walk, drain and output.
    // Returns right after the cycle in which the output beat is accepted,
    // or right after the reset when rst_k5 is set.
    task automatic do_sample(input int s, input int len, input bit tlast,
                             input int idle, input int bp,
                             input bit busy_start, input bit rst_k5);
        int slot;
        int exp_last;
        slot     = s % NTAPS;
        exp_last = (s == len - 1) ? 1 : 0;

        for (int j = 0; j < idle; j++) begin
            step();
            #1;
            check("wait.ss_tready", 32'(bus.ss_tready), 32'd1);
            check("wait.data_EN",   32'(bus.data_EN),   32'd0);
        end

        step();
        bus.ss_tvalid = 1'b1;
        bus.ss_tlast  = tlast;
        #1;
        check("in.ss_tready", 32'(bus.ss_tready), 32'd1);
        check("in.data_EN",   32'(bus.data_EN),   32'd1);
        check("in.data_WE",   32'(bus.data_WE),   32'hF);
        check("in.data_A",    32'(bus.data_A),    32'(4 * slot));
        check("in.data_zero", 32'(bus.data_zero), 32'd0);
        check("in.mac_clr",   32'(bus.mac_clr),   32'd1);
        if (int'(tlast) != exp_last) err_model = 1'b1;
        $display("txn: sample %0d accepted, slot %0d, tlast %0d", s, slot, tlast);

        for (int k = 0; k < NTAPS; k++) begin
            step();
            if (busy_start && k == 3) begin
                start       = 1'b1;
                data_length = 32'd7;
            end
            #1;
            check("mac.tap_EN",    32'(bus.tap_EN),    32'd1);
            check("mac.tap_A",     32'(bus.tap_A),     32'(4 * k));
            check("mac.data_EN",   32'(bus.data_EN),   32'd1);
            check("mac.data_WE",   32'(bus.data_WE),   32'd0);
            check("mac.data_A",    32'(bus.data_A),    32'(4 * ((slot - k + NTAPS) % NTAPS)));
            check("mac.mac_en",    32'(bus.mac_en),    32'(k != 0));
            check("mac.mac_clr",   32'(bus.mac_clr),   32'd0);
            check("mac.ss_tready", 32'(bus.ss_tready), 32'd0);
            check("mac.ap_start",  32'(ap_start),      32'd0);
            if (rst_k5 && k == 5) begin
                rst = 1'b1;
                step();
                #1;
                check_reset_state("midrst");
                rst       = 1'b0;
                err_model = 1'b0;
                $display("txn: reset during tap walk of sample %0d", s);
                return;
            end
        end

        step();
        #1;
        check("drain.mac_en",    32'(bus.mac_en),    32'd1);
        check("drain.tap_EN",    32'(bus.tap_EN),    32'd0);
        check("drain.data_EN",   32'(bus.data_EN),   32'd0);
        check("drain.sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
        check("drain.ap_idle",   32'(ap_idle),       32'd0);

        for (int b = 0; b < bp; b++) begin
            step();
            #1;
            check("bp.sm_tvalid", 32'(bus.sm_tvalid), 32'd1);
            check("bp.sm_tlast",  32'(bus.sm_tlast),  32'(exp_last));
            check("bp.ss_tready", 32'(bus.ss_tready), 32'd0);
            check("bp.mac_en",    32'(bus.mac_en),    32'd0);
        end

        step();
        bus.sm_tready = 1'b1;
        #1;
        check("out.sm_tvalid", 32'(bus.sm_tvalid), 32'd1);
        check("out.sm_tlast",  32'(bus.sm_tlast),  32'(exp_last));
        check("out.ss_tready", 32'(bus.ss_tready), 32'd0);
        check("out.err_tlast", 32'(err_tlast),     32'(err_model));
        check("out.ap_done",   32'(ap_done),       32'd0);
        $display("txn: sample %0d output, tlast %0d, backpressure %0d", s, exp_last, bp);
    endtask

    task automatic check_done(input string where);
        step();
        #1;
        check({where, ".ap_done"},   32'(ap_done),       32'd1);
        check({where, ".ap_idle"},   32'(ap_idle),       32'd1);
        check({where, ".tap_grant"}, 32'(tap_grant),     32'd1);
        check({where, ".sm_tvalid"}, 32'(bus.sm_tvalid), 32'd0);
        check({where, ".ss_tready"}, 32'(bus.ss_tready), 32'd0);
    endtask

    initial begin
        int len;
        rst         = 1'b1;
        start       = 1'b0;
        ap_ctrl_rd  = 1'b0;
        data_length = '0;
        bus.ss_tvalid = 1'b0;
        bus.ss_tlast  = 1'b0;
        bus.sm_tready = 1'b0;

        // Reset state
        step();
        step();
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Long run: wrap-around, tlast error, ignored start, backpressure,
        // then a reset in the middle of the 13th sample's tap walk.
        do_clear(600);
        for (int s = 0; s < 12; s++) begin
            do_sample(s, 600, (s == 2), $urandom_range(0, 2),
                      (s == 4) ? 5 : $urandom_range(0, 3), (s == 1), 1'b0);
        end
        do_sample(12, 600, 1'b0, 0, 0, 1'b0, 1'b1);

        // Single sample, then read-to-clear of ap_done
        do_clear(1);
        do_sample(0, 1, 1'b1, $urandom_range(0, 2), 0, 1'b0, 1'b0);
        check_done("single");
        check("single.ap_start", 32'(ap_start), 32'd0);
        step();
        ap_ctrl_rd = 1'b1;
        #1;
        step();
        #1;
        check("rd.ap_done", 32'(ap_done), 32'd0);
        check("rd.ap_idle", 32'(ap_idle), 32'd1);

        // Zero-length run ends immediately after the clear
        do_clear(0);
        check_done("len0");
        step();
        #1;
        check("len0.ss_tready_later", 32'(bus.ss_tready), 32'd0);
        check("len0.ap_idle_later",   32'(ap_idle),       32'd1);

        // Short random-length runs with correct tlast
        for (int r = 0; r < 2; r++) begin
            len = $urandom_range(2, 4);
            do_clear(len);
            for (int s = 0; s < len; s++) begin
                do_sample(s, len, (s == len - 1), $urandom_range(0, 2),
                          $urandom_range(0, 3), 1'b0, 1'b0);
            end
            check_done("rand");
            check("rand.err_tlast", 32'(err_tlast), 32'(err_model));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencing controller for the 11-tap FIR engine. Owns the ap_ctrl state (ap_start/ap_done/ap_idle), the AXI-Stream in/out handshakes, and all address/enable generation for the tap RAM and the 11-entry circular data RAM. It also issues the MAC clear/enable strobes to the arithmetic datapath. It sits between the AXI-Lite register decode, the two bram11 instances and the multiply-accumulate datapath. Data_Di, tap_Di and the MAC itself are outside this block.

## Interface
- pADDR_WIDTH, 12: RAM byte-address width.
- pDATA_WIDTH, 32: data width of data_length.
- Tape_Num, 11: number of taps, which is also the data RAM depth.

- axis_clk  in  1  clock; all logic is on the rising edge.
- axis_rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse when software writes 1 to bit 0 of register 0x00.
- ap_ctrl_rd  in  1  one-cycle pulse when register 0x00 is read.
- data_length  in  pDATA_WIDTH  number of samples; sampled at start.
- ap_start, ap_done, ap_idle  out  1 each  status bits 0, 1 and 2 of register 0x00.
- tap_grant  out  1  high when the AXI-Lite side may access the tap RAM (= ap_idle).
- ss_tvalid, ss_tlast  in  1 each; ss_tready  out  1.
- sm_tready  in  1; sm_tvalid, sm_tlast  out  1 each.
- data_EN  out  1; data_WE  out  4; data_A  out  pADDR_WIDTH; data_zero  out  1 (forces data_Di to 0).
- tap_EN  out  1; tap_A  out  pADDR_WIDTH. These are driven only while tap_grant is 0.
- mac_clr  out  1  clears the accumulator.
- mac_en  out  1  accumulates tap_Do*data_Do this cycle.
- err_tlast  out  1  sticky flag for an ss_tlast mismatch.

## Operation
- States: IDLE, CLEAR, WAIT_IN, MAC, DRAIN, OUT.
- **IDLE**
  - ap_idle=1.
  - A start pulse latches data_length into len, sets n=0, wptr=0, ap_start=1 and ap_done=0, and moves to CLEAR.
  - A start pulse in any other state is ignored.
- **CLEAR** (Tape_Num cycles, i=0..10)
  - data_EN=1, data_WE=4'hF, data_zero=1, data_A=4*i.
  - Then go to WAIT_IN, or to IDLE with ap_done=1 if len==0.
- **WAIT_IN**
  - ss_tready=1.
  - On ss_tvalid: data_EN=1, data_WE=4'hF, data_A=4*wptr, mac_clr=1, ap_start=0.
  - If ss_tlast != (n==len-1), set err_tlast.
  - Go to MAC with k=0.
- **MAC** (k=0..10, one cycle each)
  - tap_EN=1, tap_A=4*k.
  - data_EN=1, data_WE=0, data_A=4*((wptr-k) mod 11).
  - After k=10, go to DRAIN.
- **mac_en**: registered copy of "state==MAC", so it is high from the cycle after k=0 through DRAIN (11 cycles). This matches the bram11 one-cycle read latency.
- **DRAIN**: one cycle, then go to OUT.
- **OUT**
  - sm_tvalid=1, sm_tlast=(n==len-1).
  - On sm_tready: wptr advances (10 wraps to 0) and n increments.
  - If this was the last sample, go to IDLE and set ap_done=1; otherwise go to WAIT_IN.
- **ap_done**: sticky. Cleared by ap_ctrl_rd while in IDLE, or by an accepted start.
- **Widths**: n and len are 32-bit unsigned. wptr and k are 4-bit, range 0..10, with explicit wrap.
- **Reset** (in any state, including mid-MAC or mid-OUT):
  - state=IDLE; ap_idle=1, tap_grant=1.
  - ap_start=0, ap_done=0, err_tlast=0.
  - All strobes, valids, readies, enables and WE are 0; addresses are 0.
  - n=0, wptr=0, k=0.
- **Tap-lock rule**: the tap RAM is never written by this block, and tap_grant=0 whenever the engine is busy.

## Timing
- Strobe sourcing:
  - ss_tready and sm_tvalid are Moore outputs of the state.
  - data_*/tap_* are registered-free decodes of state and counters.
  - mac_en is registered.
- The cycle after the start pulse, CLEAR begins, with ap_idle=0 and tap_grant=0.
- If ss handshake is at cycle t:
  - MAC runs t+1..t+11; mac_en is high t+2..t+12; DRAIN is t+12.
  - sm_tvalid rises at t+13.
  - The earliest next ss_tready is t+14, giving a minimum of 14 cycles per sample.
- sm_tvalid, sm_tlast and state hold unchanged while sm_tready=0; ss_tready stays 0 meanwhile.
- The write to data[wptr] at cycle t is read back by MAC k=0 at t+1 (bram11 write, then next-cycle read).
- On the last sample's sm handshake at cycle u: ap_done=1 and ap_idle=1 from u+1.

## Test plan
- **Reset and start**: reset, then start with data_length=600 → data_A steps 0x00,0x04,…,0x28 with data_WE=F and data_zero=1 over 11 cycles. ap_idle is 0 from the cycle after start, and ss_tready rises after CLEAR.
- **Single sample**: data_length=1, one sample at cycle t →
  - tap_A sequence 0,4,…,40.
  - data_A sequence 0,40,36,…,4.
  - mac_clr at t; mac_en for 11 cycles.
  - sm_tvalid with sm_tlast=1 at t+13.
  - After the handshake, ap_done=1 and ap_idle=1. ap_ctrl_rd then clears ap_done.
- **Backpressure**: hold sm_tready=0 for 5 cycles in OUT → sm_tvalid stays 1, ss_tready stays 0, wptr is unchanged. The handshake on the 6th cycle advances wptr.
- **Wrap-around**: stream 12 samples → sample 11 is written at 0x28 and sample 12 at 0x00. MAC for sample 12 reads data_A 0x00,0x28,0x24,…,0x04.
- **Boundary and err_tlast**:
  - data_length=0 → IDLE with ap_done=1 right after CLEAR; no ss_tready after CLEAR.
  - A start pulse while busy has no effect.
  - ss_tlast=1 on sample 3 of 600 → err_tlast=1 and stays set.
- **Mid-operation reset**: assert axis_rst during MAC k=5 → next cycle every output is at its reset value. A new start runs CLEAR from address 0.
